// File: rtl/tmds_pkg.sv
// ---------------------------------------------------------------------------
// tmds_pkg
// Shared definitions for the TMDS/HDMI encoder: period-type codes, the four
// control-period tokens, the guard-band symbols, the TERC4 table and small
// helper functions used by every lane.
// ---------------------------------------------------------------------------
package tmds_pkg;

    typedef enum logic [2:0] {
        MODE_CTRL      = 3'd0,
        MODE_VIDEO     = 3'd1,
        MODE_VIDEO_GB  = 3'd2,
        MODE_ISLAND    = 3'd3,
        MODE_ISLAND_GB = 3'd4
    } mode_e;

    // Control tokens indexed by {C1,C0} (channel 0: {VS,HS}).
    localparam logic [9:0] CTRL_TOK [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    localparam logic [9:0] GB_2CC = 10'h2CC;
    localparam logic [9:0] GB_133 = 10'h133;

    localparam logic [9:0] TERC4_TBL [16] = '{
        10'h29C, 10'h263, 10'h2E4, 10'h2E2,
        10'h171, 10'h11E, 10'h18E, 10'h13C,
        10'h2CC, 10'h139, 10'h19C, 10'h2C6,
        10'h28E, 10'h271, 10'h163, 10'h2C3
    };

    function automatic logic [9:0] terc4(input logic [3:0] nib);
        return TERC4_TBL[nib];
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/tmds_lane_enc.sv
// ---------------------------------------------------------------------------
// tmds_lane_enc
// One TMDS channel: stage-1 input register (plus xnor-select and legality),
// stage-2 symbol mux with DVI DC balancing and a 5-bit disparity counter.
//
// Parameters
//   CH0      : 1 -> this lane carries HS/VS (control tokens, TERC4 low bits)
//   GB_ALT   : 1 -> video guard band is 0x133 instead of 0x2CC (channel 1)
//   DVI_ONLY : 1 -> island modes are treated as illegal
// Ports
//   I_clk, I_rst   : clock, asynchronous active-high reset
//   I_mode         : period type
//   I_hs, I_vs     : sync inputs (used by CH0 lane)
//   I_ctl          : {CTLb,CTLa} for this lane (ignored on CH0 lane)
//   I_data, I_aux  : pixel byte / TERC4 nibble
//   O_q            : encoded 10-bit symbol, two edges after input capture
//   O_mode_err     : stage-1 illegal-mode flag (reaches O_q on next edge)
// ---------------------------------------------------------------------------
module tmds_lane_enc
    import tmds_pkg::*;
#(
    parameter bit CH0      = 1'b0,
    parameter bit GB_ALT   = 1'b0,
    parameter bit DVI_ONLY = 1'b0
) (
    input  logic       I_clk,
    input  logic       I_rst,
    input  logic [2:0] I_mode,
    input  logic       I_hs,
    input  logic       I_vs,
    input  logic [1:0] I_ctl,
    input  logic [7:0] I_data,
    input  logic [3:0] I_aux,
    output logic [9:0] O_q,
    output logic       O_mode_err
);

    // ---------------- stage 1 ----------------
    mode_e      mode_q, mode_d;
    logic       hs_q, vs_q;
    logic [1:0] ctl_q;
    logic [7:0] data_q;
    logic [3:0] aux_q;
    logic       xnor_q, xnor_d;
    logic       err_q, err_d;
    logic [3:0] n1_in;

    always_comb begin
        err_d = !((I_mode <= 3'd2) || (!DVI_ONLY && (I_mode <= 3'd4)));
        // Illegal codes collapse to CTRL so the lane emits a control token.
        mode_d = err_d ? MODE_CTRL : mode_e'(I_mode);
        n1_in  = popcount8(I_data);
        xnor_d = (n1_in > 4'd4) || ((n1_in == 4'd4) && !I_data[0]);
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            mode_q <= MODE_CTRL;
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
            ctl_q  <= '0;
            data_q <= '0;
            aux_q  <= '0;
            xnor_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            hs_q   <= I_hs;
            vs_q   <= I_vs;
            ctl_q  <= I_ctl;
            data_q <= I_data;
            aux_q  <= I_aux;
            xnor_q <= xnor_d;
            err_q  <= err_d;
        end
    end

    assign O_mode_err = err_q;

    // ---------------- stage 2 ----------------
    logic [9:0] q_q, q_d;
    logic [4:0] cnt_q, cnt_d;
    logic [8:0] qm;
    logic [3:0] n1;
    logic [4:0] diff;       // N1 - N0 of q_m[7:0], two's complement
    logic       cnt_pos, cnt_neg;
    logic [9:0] vid_q;
    logic [4:0] vid_cnt;
    logic [1:0] sel;

    always_comb begin
        qm    = '0;
        qm[0] = data_q[0];
        for (int unsigned i = 1; i < 8; i++) begin
            qm[i] = xnor_q ? ~(qm[i-1] ^ data_q[i]) : (qm[i-1] ^ data_q[i]);
        end
        qm[8]   = ~xnor_q;
        n1      = popcount8(qm[7:0]);
        diff    = {n1, 1'b0} - 5'd8;
        cnt_pos = !cnt_q[4] && (cnt_q != '0);
        cnt_neg = cnt_q[4];
        if ((cnt_q == '0) || (n1 == 4'd4)) begin
            vid_q   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            vid_cnt = qm[8] ? (cnt_q + diff) : (cnt_q - diff);
        end else if ((cnt_pos && (n1 > 4'd4)) || (cnt_neg && (n1 < 4'd4))) begin
            vid_q   = {1'b1, qm[8], ~qm[7:0]};
            vid_cnt = cnt_q + {3'b000, qm[8], 1'b0} - diff;
        end else begin
            vid_q   = {1'b0, qm[8], qm[7:0]};
            vid_cnt = cnt_q - {3'b000, ~qm[8], 1'b0} + diff;
        end
    end

    always_comb begin
        sel   = CH0 ? {vs_q, hs_q} : ctl_q;
        cnt_d = '0;
        case (mode_q)
            MODE_VIDEO: begin
                q_d   = vid_q;
                cnt_d = vid_cnt;
            end
            MODE_VIDEO_GB:  q_d = GB_ALT ? GB_133 : GB_2CC;
            MODE_ISLAND:    q_d = CH0 ? terc4({aux_q[3:2], vs_q, hs_q}) : terc4(aux_q);
            MODE_ISLAND_GB: q_d = CH0 ? terc4({2'b11, vs_q, hs_q}) : GB_133;
            default:        q_d = CTRL_TOK[sel];
        endcase
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            q_q   <= '0;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

    assign O_q = q_q;

endmodule

// File: rtl/tmds_hdmi_encoder.sv
// ---------------------------------------------------------------------------
// tmds_hdmi_encoder
// Multi-channel TMDS/HDMI symbol encoder (DVI video, control, guard bands,
// TERC4 data islands) with a 2-edge pipeline and a sticky illegal-mode flag.
//
// Parameters
//   NUM_CH   : number of TMDS channels (1..4); channel 0 carries HS/VS
//   DVI_ONLY : 1 -> island modes are illegal
// Ports
//   I_clk, I_rst : pixel clock, asynchronous active-high reset
//   I_mode       : 0 CTRL, 1 VIDEO, 2 VIDEO_GB, 3 ISLAND, 4 ISLAND_GB
//   I_hs, I_vs   : syncs
//   I_ctl        : {CTLb,CTLa} per channel (channel-0 pair ignored)
//   I_data       : pixel byte per channel, channel n at [8n+7:8n]
//   I_aux        : TERC4 nibble per channel, channel n at [4n+3:4n]
//   O_q          : 10-bit symbol per channel, bit 0 transmitted first
//   O_mode_err   : sticky illegal-mode flag, cleared only by reset
// ---------------------------------------------------------------------------
module tmds_hdmi_encoder
    import tmds_pkg::*;
#(
    parameter int unsigned NUM_CH   = 3,
    parameter bit          DVI_ONLY = 1'b0
) (
    input  logic                  I_clk,
    input  logic                  I_rst,
    input  logic [2:0]            I_mode,
    input  logic                  I_hs,
    input  logic                  I_vs,
    input  logic [2*NUM_CH-1:0]   I_ctl,
    input  logic [8*NUM_CH-1:0]   I_data,
    input  logic [4*NUM_CH-1:0]   I_aux,
    output logic [10*NUM_CH-1:0]  O_q,
    output logic                  O_mode_err
);

    logic [NUM_CH-1:0] lane_err;
    logic              err_q, err_d;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        tmds_lane_enc #(
            .CH0      (g == 0),
            .GB_ALT   (g == 1),
            .DVI_ONLY (DVI_ONLY)
        ) u_lane (
            .I_clk      (I_clk),
            .I_rst      (I_rst),
            .I_mode     (I_mode),
            .I_hs       (I_hs),
            .I_vs       (I_vs),
            .I_ctl      (I_ctl[2*g +: 2]),
            .I_data     (I_data[8*g +: 8]),
            .I_aux      (I_aux[4*g +: 4]),
            .O_q        (O_q[10*g +: 10]),
            .O_mode_err (lane_err[g])
        );
    end

    // Lane flags come from stage 1, so the sticky bit sets on the same edge
    // the offending symbol is registered onto O_q.
    always_comb err_d = err_q | (|lane_err);

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign O_mode_err = err_q;

endmodule

// File: tb/tb_tmds_hdmi_encoder.sv
// ---------------------------------------------------------------------------
// tb_tmds_hdmi_encoder
// Drives a 3-channel HDMI encoder and a 1-channel DVI-only encoder from the
// same stimulus. Expected symbols are queued as each cycle is driven and
// popped when the DUT output for that cycle appears.
// ---------------------------------------------------------------------------
module tb_tmds_hdmi_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  mode;
    logic        hs, vs;
    logic [5:0]  ctl;
    logic [23:0] data;
    logic [11:0] aux;
    logic [29:0] q3;
    logic        err3;
    logic [9:0]  q1;
    logic        err1;

    always #5 clk = ~clk;

    tmds_hdmi_encoder #(.NUM_CH(3), .DVI_ONLY(1'b0)) dut (
        .I_clk(clk), .I_rst(rst), .I_mode(mode), .I_hs(hs), .I_vs(vs),
        .I_ctl(ctl), .I_data(data), .I_aux(aux), .O_q(q3), .O_mode_err(err3)
    );

    tmds_hdmi_encoder #(.NUM_CH(1), .DVI_ONLY(1'b1)) dut1 (
        .I_clk(clk), .I_rst(rst), .I_mode(mode), .I_hs(hs), .I_vs(vs),
        .I_ctl(ctl[1:0]), .I_data(data[7:0]), .I_aux(aux[3:0]), .O_q(q1), .O_mode_err(err1)
    );

    typedef struct {
        logic [29:0] q3;
        logic        err3;
        logic [9:0]  q1;
        logic        err1;
    } exp_t;

    typedef struct {
        logic [2:0]  mode;
        logic        hs, vs;
        logic [5:0]  ctl;
        logic [23:0] data;
        logic [11:0] aux;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    vec_t tv[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   mcnt[3];

    function automatic vec_t mk(input logic [2:0] md, input logic h, input logic v,
                                input logic [5:0] c, input logic [23:0] d, input logic [11:0] a,
                                input logic [9:0] e2, input logic [9:0] e1, input logic [9:0] e0,
                                input logic er3, input logic [9:0] eq1, input logic er1);
        vec_t r;
        r.mode = md; r.hs = h; r.vs = v; r.ctl = c; r.data = d; r.aux = a;
        r.e.q3 = {e2, e1, e0}; r.e.err3 = er3; r.e.q1 = eq1; r.e.err1 = er1;
        return r;
    endfunction

    function automatic logic [9:0] tok(input logic [1:0] s);
        case (s)
            2'b00:   return 10'h354;
            2'b01:   return 10'h0AB;
            2'b10:   return 10'h154;
            default: return 10'h2AB;
        endcase
    endfunction

    // Reference DVI 1.0 encoder with a wrapping 5-bit signed counter.
    function automatic void vid_model(input logic [7:0] d, input int cin,
                                      output logic [9:0] q, output int cout);
        int nd, n1, n0;
        logic x;
        logic [8:0] m;
        nd = $countones(d);
        x = (nd > 4) || (nd == 4 && d[0] == 1'b0);
        m[0] = d[0];
        for (int i = 1; i < 8; i++) m[i] = x ? (m[i-1] ~^ d[i]) : (m[i-1] ^ d[i]);
        m[8] = !x;
        n1 = $countones(m[7:0]);
        n0 = 8 - n1;
        if (cin == 0 || n1 == n0) begin
            q = {~m[8], m[8], (m[8] ? m[7:0] : ~m[7:0])};
            cout = m[8] ? (cin + n1 - n0) : (cin + n0 - n1);
        end else if ((cin > 0 && n1 > n0) || (cin < 0 && n0 > n1)) begin
            q = {1'b1, m[8], ~m[7:0]};
            cout = cin + (m[8] ? 2 : 0) + n0 - n1;
        end else begin
            q = {1'b0, m[8], m[7:0]};
            cout = cin - (m[8] ? 0 : 2) + n1 - n0;
        end
        if (cout > 15) cout -= 32;
        if (cout < -16) cout += 32;
    endfunction

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 3))
            0:       return 8'h00;
            1:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic cmp(input string nm, input logic [29:0] act, input logic [29:0] want);
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s (vector %0d): got %h, want %h", nm, n_vec, act, want);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() > 1) begin
            e = sb.pop_front();
            n_vec++;
            cmp("q3", q3, e.q3);
            cmp("err3", {29'b0, err3}, {29'b0, e.err3});
            cmp("q1", {20'b0, q1}, {20'b0, e.q1});
            cmp("err1", {29'b0, err1}, {29'b0, e.err1});
        end
    endtask

    task automatic chk_zero(input string nm);
        n_vec++;
        cmp({nm, "_q3"}, q3, 30'b0);
        cmp({nm, "_err3"}, {29'b0, err3}, 30'b0);
        cmp({nm, "_q1"}, {20'b0, q1}, 30'b0);
        cmp({nm, "_err1"}, {29'b0, err1}, 30'b0);
    endtask

    task automatic step(input logic [2:0] md, input logic h, input logic v, input logic [5:0] c,
                        input logic [23:0] d, input logic [11:0] a, input exp_t e);
        mode = md; hs = h; vs = v; ctl = c; data = d; aux = a;
        sb.push_back(e);
        @(posedge clk); #1;
        check_out();
    endtask

    task automatic push_prefill();
        exp_t e;
        e.q3 = {3{10'h354}}; e.err3 = 1'b0; e.q1 = 10'h354; e.err1 = 1'b0;
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        logic [9:0] sym;
        logic [29:0] eq;
        logic [2:0] md;
        logic h, v;
        logic [5:0] c;
        logic [23:0] d;
        int nc;

        rst = 1'b1; mode = '0; hs = 0; vs = 0; ctl = '0; data = '0; aux = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        push_prefill();

        //       mode  hs vs ctl        data        aux      ch2     ch1     ch0    e3  q1      e1
        tv.push_back(mk(3'd0, 1, 0, 6'b000011, 24'h0,      12'h0,   10'h354, 10'h354, 10'h0AB, 0, 10'h0AB, 0));
        tv.push_back(mk(3'd0, 0, 1, 6'b100100, 24'h0,      12'h0,   10'h154, 10'h0AB, 10'h154, 0, 10'h154, 0));
        tv.push_back(mk(3'd0, 1, 1, 6'b001100, 24'h0,      12'h0,   10'h354, 10'h2AB, 10'h2AB, 0, 10'h2AB, 0));
        tv.push_back(mk(3'd1, 0, 0, 6'b0,      24'h000000, 12'h0,   10'h100, 10'h100, 10'h100, 0, 10'h100, 0));
        tv.push_back(mk(3'd1, 0, 0, 6'b0,      24'h000000, 12'h0,   10'h3FF, 10'h3FF, 10'h3FF, 0, 10'h3FF, 0));
        tv.push_back(mk(3'd0, 0, 0, 6'b0,      24'h0,      12'h0,   10'h354, 10'h354, 10'h354, 0, 10'h354, 0));
        tv.push_back(mk(3'd1, 0, 0, 6'b0,      24'hFFFFFF, 12'h0,   10'h200, 10'h200, 10'h200, 0, 10'h200, 0));
        tv.push_back(mk(3'd0, 0, 0, 6'b0,      24'h0,      12'h0,   10'h354, 10'h354, 10'h354, 0, 10'h354, 0));
        tv.push_back(mk(3'd1, 0, 0, 6'b0,      24'hFFFFFF, 12'h0,   10'h200, 10'h200, 10'h200, 0, 10'h200, 0));
        tv.push_back(mk(3'd2, 1, 1, 6'b0,      24'h0,      12'h0,   10'h2CC, 10'h133, 10'h2CC, 0, 10'h2CC, 0));
        tv.push_back(mk(3'd4, 1, 1, 6'b0,      24'h0,      12'h0,   10'h133, 10'h133, 10'h2C3, 0, 10'h2AB, 1));
        tv.push_back(mk(3'd3, 0, 1, 6'b0,      24'h0,      12'h50C, 10'h11E, 10'h29C, 10'h163, 0, 10'h154, 1));
        tv.push_back(mk(3'd3, 1, 0, 6'b0,      24'h0,      12'hFA3, 10'h2C3, 10'h19C, 10'h263, 0, 10'h0AB, 1));
        tv.push_back(mk(3'd6, 0, 0, 6'b0,      24'h0,      12'h0,   10'h354, 10'h354, 10'h354, 1, 10'h354, 1));
        tv.push_back(mk(3'd7, 1, 0, 6'b111000, 24'h0,      12'h0,   10'h2AB, 10'h154, 10'h0AB, 1, 10'h0AB, 1));
        tv.push_back(mk(3'd5, 0, 1, 6'b010100, 24'h0,      12'h0,   10'h0AB, 10'h0AB, 10'h154, 1, 10'h154, 1));
        tv.push_back(mk(3'd1, 0, 0, 6'b0,      24'h000000, 12'h0,   10'h100, 10'h100, 10'h100, 1, 10'h100, 1));
        tv.push_back(mk(3'd2, 0, 0, 6'b0,      24'h0,      12'h0,   10'h2CC, 10'h133, 10'h2CC, 1, 10'h2CC, 1));
        tv.push_back(mk(3'd0, 0, 0, 6'b0,      24'h0,      12'h0,   10'h354, 10'h354, 10'h354, 1, 10'h354, 1));

        foreach (tv[i]) step(tv[i].mode, tv[i].hs, tv[i].vs, tv[i].ctl, tv[i].data, tv[i].aux, tv[i].e);

        // Asynchronous reset in the middle of a cycle.
        #2;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst_hold");
        rst = 1'b0;
        push_prefill();
        for (int c2 = 0; c2 < 3; c2++) mcnt[c2] = 0;

        for (int k = 0; k < 300; k++) begin
            h = 1'($urandom); v = 1'($urandom); c = 6'($urandom);
            if ($urandom_range(0, 9) < 8) begin
                md = 3'd1;
                d = {pick(), pick(), pick()};
                for (int ch = 0; ch < 3; ch++) begin
                    vid_model(d[8*ch +: 8], mcnt[ch], sym, nc);
                    mcnt[ch] = nc;
                    eq[10*ch +: 10] = sym;
                end
            end else begin
                md = 3'd0;
                d = 24'($urandom);
                for (int ch = 0; ch < 3; ch++) mcnt[ch] = 0;
                eq = {tok(c[5:4]), tok(c[3:2]), tok({v, h})};
            end
            e.q3 = eq; e.err3 = 1'b0; e.q1 = eq[9:0]; e.err1 = 1'b0;
            step(md, h, v, c, d, 12'($urandom), e);
        end

        e.q3 = {3{10'h354}}; e.err3 = 1'b0; e.q1 = 10'h354; e.err1 = 1'b0;
        step(3'd0, 0, 0, 6'b0, 24'h0, 12'h0, e);
        step(3'd0, 0, 0, 6'b0, 24'h0, 12'h0, e);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/tmds_hdmi_encoder.md
TMDS_HDMI_ENCODER -- requirements
Module: tmds_hdmi_encoder

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, meaning number of TMDS channels (legal range 1..4); channel 0 carries HS/VS.
REQ-002 SHALL have parameter DVI_ONLY, default 0; when 1, the island modes are illegal.
REQ-003 SHALL have port I_clk, input, 1 bit: the single clock (pixel clock); one clock, all logic on its rising edge.
REQ-004 SHALL have port I_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port I_mode, input, 3 bits: period type. 0 CTRL, 1 VIDEO, 2 VIDEO_GB, 3 ISLAND, 4 ISLAND_GB; 5..7 illegal.
REQ-006 SHALL have port I_hs, input, 1 bit: horizontal sync.
REQ-007 SHALL have port I_vs, input, 1 bit: vertical sync.
REQ-008 SHALL have port I_ctl, input, 2*NUM_CH bits: {CTLb,CTLa} per channel; the channel-0 pair is ignored.
REQ-009 SHALL have port I_data, input, 8*NUM_CH bits: pixel byte per channel; channel n is at [8n+7:8n].
REQ-010 SHALL have port I_aux, input, 4*NUM_CH bits: TERC4 nibble per channel; channel n is at [4n+3:4n].
REQ-011 SHALL have port O_q, output, 10*NUM_CH bits: encoded symbols; bit 0 is transmitted first.
REQ-012 SHALL have port O_mode_err, output, 1 bit: sticky illegal-mode flag.

Function
REQ-013 SHALL use a 2-stage pipeline: inputs sampled at edge t appear on O_q at edge t+2, for every mode.
REQ-014 Stage 1 SHALL register the inputs and compute a per-channel xnor-select: 1 if popcount(data) > 4, or if popcount = 4 and data[0] = 0.
REQ-015 In VIDEO, stage 2 SHALL form q_m[8:0] by the XOR/XNOR chain and apply DVI 1.0 DC balancing against a per-channel 5-bit signed disparity counter; the counter update SHALL be exact two's-complement with no saturation.
REQ-016 CTRL SHALL emit on channel 0, for {VS,HS} = 00/01/10/11: 0x354/0x0AB/0x154/0x2AB respectively; channel n>0 SHALL use {CTLb,CTLa} with the same table.
REQ-017 VIDEO_GB SHALL emit 0x2CC on channel 0, 0x133 on channel 1, and 0x2CC on channels >= 2.
REQ-018 ISLAND SHALL emit TERC4(aux nibble) on every channel, except that channel 0 SHALL use TERC4({aux[3:2],VS,HS}).
REQ-019 ISLAND_GB SHALL emit TERC4({1,1,VS,HS}) on channel 0 and 0x133 on channels >= 1.
REQ-020 The TERC4 table SHALL be per HDMI 1.4 section 5.4.3 (e.g. nibble 0 -> 0x29C, nibble F -> 0x2C3).
REQ-021 The disparity counter SHALL clear to 0 on any cycle whose stage-1 mode is not VIDEO.
REQ-022 A first VIDEO cycle after a non-VIDEO cycle SHALL therefore start from disparity 0.
REQ-023 An illegal mode (5..7, or 3/4 when DVI_ONLY=1) SHALL be encoded as CTRL with the same HS/VS/CTL inputs.
REQ-024 An illegal mode SHALL set O_mode_err at the same edge its symbol reaches O_q.
REQ-025 O_mode_err SHALL clear only on reset.
REQ-026 Mode changes on consecutive cycles SHALL produce no gap or bubble: each output cycle reflects exactly its input cycle's mode.

Reset
REQ-027 While I_rst=1: O_q = all zeros, all disparity counters = 0, O_mode_err = 0.
REQ-028 While I_rst=1, stage-1 registers SHALL hold mode CTRL with HS=VS=0 and CTL=0.
REQ-029 The first edge after I_rst falls SHALL drive 0x354 on every channel.
REQ-030 Reset asserted mid-period SHALL take effect immediately (asynchronously); no partial symbol is held.

Structure
REQ-031 Package tmds_pkg SHALL hold: the mode codes, the four control tokens, the guard-band constants 0x2CC/0x133, and the 16-entry TERC4 table.
REQ-032 Sub-module tmds_lane_enc SHALL implement one channel (stages, disparity counter, mode mux) with a CH0 parameter selecting HS/VS behaviour.
REQ-033 The top level SHALL generate NUM_CH instances of tmds_lane_enc and OR together their per-lane error flags into the sticky flag.

Verification
REQ-034 Reset release, then mode=CTRL with HS=1, VS=0 -> O_q ch0 = 0x0AB two cycles later; ch1/ch2 with CTL=00 -> 0x354.
REQ-035 VIDEO 0x00, 0x00 on ch0 after CTRL -> 0x100 (disparity -8), then 0x3FF (disparity +2).
REQ-036 VIDEO 0xFF on the first video cycle -> 0x200; then a CTRL cycle followed by VIDEO 0xFF -> 0x200 again (counter was cleared).
REQ-037 Sequence VIDEO_GB, ISLAND_GB with HS=VS=1, ISLAND with aux ch1=0x0 -> back-to-back outputs: 0x2CC/0x133/0x2CC; ch0 = TERC4(F) = 0x2C3, ch1 = 0x133; ch1 = 0x29C.
REQ-038 mode=6 with HS=VS=0 -> O_q ch0 = 0x354 and O_mode_err=1, which stays 1 through later legal modes until I_rst.
REQ-039 With DVI_ONLY=1, mode=3 -> CTRL symbols and O_mode_err=1; with NUM_CH=1 -> output width is 10 bits and scenario REQ-035 still passes.
